arb_2_1_32: RTL

ARB_2_1_32 -- requirements
Module: arb_2_1_32

---
 rtl/arb_pkg.sv | 14 +
 rtl/mux_2_1_32.sv | 15 +
 rtl/arb_2_1_32.sv | 113 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 2:1 valid/ready arbiter: FSM encoding, source IDs
// and the transfer-counter width.
package arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic SRC0  = 1'b0;
    localparam logic SRC1  = 1'b1;
    localparam int   CNT_W = 16;

endpackage

// File: rtl/mux_2_1_32.sv
// Plain 2:1 payload multiplexer; sel_i picks d1_i when it names source 1.
module mux_2_1_32
    import arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = (sel_i == SRC1) ? d1_i : d0_i;

endmodule

// File: rtl/arb_2_1_32.sv
// Two-requester valid/ready arbiter with a single registered output slot.
// Round-robin on contention; define ARB_FIXED_PRIO_EN to make requester 0 always win.
module arb_2_1_32
    import arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             src_q, src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifndef ARB_FIXED_PRIO_EN
    logic             last_q, last_d;
`endif

    logic             grant;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] mux_y;

    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        grant = SRC0;
        if (in0_valid && in1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
            grant = SRC0;
`else
            grant = (last_q == SRC0) ? SRC1 : SRC0;
`endif
        end else if (in1_valid) begin
            grant = SRC1;
        end
    end

    // A FULL slot frees up in the same cycle the consumer takes it, giving zero-bubble flow.
    assign slot_free = (state_q == EMPTY) || out_ready;
    assign accept    = rst_n && slot_free && (in0_valid || in1_valid);
    assign in0_ready = accept && (grant == SRC0);
    assign in1_ready = accept && (grant == SRC1);

    mux_2_1_32 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel_i (grant),
        .d0_i  (in0_data),
        .d1_i  (in1_data),
        .y_o   (mux_y)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (accept) begin
            state_d = FULL;
            data_d  = mux_y;
            src_d   = grant;
`ifndef ARB_FIXED_PRIO_EN
            last_d  = grant;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= SRC0;
            cnt_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= SRC1;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign xfer_cnt  = cnt_q;

endmodule
